// File: rtl/dmem_stage.sv
`default_nettype none
// ============================================================================
// Module      : dmem_stage
// Description : Data-memory stage of a RISC-V core. It takes one access per
//               dmem_en strobe: either a byte/half/word store with byte-lane
//               enables, or a load with sign/zero extension. An access that
//               breaks the rules is rejected and reported with a fault code.
//               Both loads and faults have one cycle of latency. The storage
//               is a synchronous-read array that can be inferred as block RAM.
// Ports       : clk        - clock; all state changes on its rising edge
//               rst_n      - synchronous, active-low reset (memory is kept)
//               dmem_en    - access strobe
//               re / we    - load / store request
//               funct3     - size/sign code (B, H, W, BU, HU)
//               addr       - byte address
//               wdata      - store data, LSB-aligned
//               rdata      - extended load result, held until the next load
//               rvalid     - one-cycle pulse for a completed load
//               fault      - one-cycle pulse for a rejected access
//               fault_code - 01 misaligned, 10 out of range, 11 illegal op
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_stage #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmem_en,
    input  logic        re,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        fault,
    output logic [1:0]  fault_code
);

    localparam int          c_AW    = $clog2(DEPTH);
    localparam logic [32:0] c_LIMIT = 33'(4 * DEPTH);

    localparam logic [1:0] c_CODE_OK    = 2'b00;
    localparam logic [1:0] c_CODE_MISAL = 2'b01;
    localparam logic [1:0] c_CODE_RANGE = 2'b10;
    localparam logic [1:0] c_CODE_ILLEG = 2'b11;

    // ------------------------------------------------------------------
    // Access qualification and classification
    // ------------------------------------------------------------------
    logic             w_acc;
    logic             w_illegal;
    logic             w_misal;
    logic             w_range;
    logic [1:0]       w_code;
    logic             w_ld;
    logic             w_st;
    logic [c_AW-1:0]  w_idx;
    logic [3:0]       w_be;
    logic [31:0]      w_wlanes;

    assign w_acc     = rst_n & dmem_en & (re | we);
    assign w_illegal = (re & we) | (we & funct3[2]) |
                       (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);
    assign w_misal   = ((funct3[1:0] == 2'b01) & addr[0]) |
                       ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
    assign w_range   = ({1'b0, addr} >= c_LIMIT);

    always_comb begin
        w_code = c_CODE_OK;
        if (w_illegal)    w_code = c_CODE_ILLEG;
        else if (w_misal) w_code = c_CODE_MISAL;
        else if (w_range) w_code = c_CODE_RANGE;
    end

    // Only legal accesses (code 00) reach the array; the range check above
    // guarantees the word index fits in c_AW bits.
    assign w_ld  = w_acc & re & (w_code == c_CODE_OK);
    assign w_st  = w_acc & we & (w_code == c_CODE_OK);
    assign w_idx = addr[c_AW+1:2];

    // Replicate store data across lanes so the byte enables alone place it.
    always_comb begin
        w_be     = 4'b1111;
        w_wlanes = wdata;
        case (funct3[1:0])
            2'b00: begin
                w_be     = 4'b0001 << addr[1:0];
                w_wlanes = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_be     = addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{wdata[15:0]}};
            end
            default: begin
                w_be     = 4'b1111;
                w_wlanes = wdata;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage: byte-enabled write, registered read. Not reset, so the
    // contents survive reset. Loads and stores never share a cycle (re&we is
    // illegal), so a load one cycle after a store sees the new data.
    // ------------------------------------------------------------------
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rd_word;
    logic [2:0]  r_ld_f3;
    logic [1:0]  r_ld_off;

    always_ff @(posedge clk) begin
        if (w_st) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
            end
        end
        if (w_ld) begin
            r_rd_word <= r_mem[w_idx];
            r_ld_f3   <= funct3;
            r_ld_off  <= addr[1:0];
        end
    end

    // ------------------------------------------------------------------
    // Lane selection and extension of the registered read word
    // ------------------------------------------------------------------
    logic [31:0] w_sh;
    logic [31:0] w_ext;

    assign w_sh = r_rd_word >> {r_ld_off, 3'b000};

    always_comb begin
        w_ext = w_sh;
        case (r_ld_f3)
            3'b000:  w_ext = {{24{w_sh[7]}},  w_sh[7:0]};
            3'b001:  w_ext = {{16{w_sh[15]}}, w_sh[15:0]};
            3'b100:  w_ext = {24'h0, w_sh[7:0]};
            3'b101:  w_ext = {16'h0, w_sh[15:0]};
            default: w_ext = w_sh;
        endcase
    end

    // ------------------------------------------------------------------
    // Output state
    // ------------------------------------------------------------------
    logic        r_ld_valid;
    logic [31:0] r_rdata;
    logic        r_fault;
    logic [1:0]  r_fault_code;
    logic        w_ld_done;

    // A load completing in a cycle where reset is asserted is cancelled:
    // no rvalid, and the reset branch below discards its data.
    assign w_ld_done = r_ld_valid & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ld_valid   <= 1'b0;
            r_rdata      <= 32'h0;
            r_fault      <= 1'b0;
            r_fault_code <= c_CODE_OK;
        end else begin
            r_ld_valid <= w_ld;
            r_fault    <= w_acc & (w_code != c_CODE_OK);
            if (w_acc && (w_code != c_CODE_OK)) r_fault_code <= w_code;
            // Capture the completed load so rdata holds it afterwards.
            if (r_ld_valid) r_rdata <= w_ext;
        end
    end

    // rdata shows the fresh extended value in the completion cycle and the
    // captured copy at all other times.
    assign rdata      = w_ld_done ? w_ext : r_rdata;
    assign rvalid     = w_ld_done;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;

endmodule
`default_nettype wire

// File: tb/tb_dmem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_stage
// Description : Self-checking bench for dmem_stage. It uses a byte-array
//               reference model and a mix of directed and random accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_stage;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst_n;
    logic        dmem_en;
    logic        re;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        fault;
    logic [1:0]  fault_code;

    dmem_stage #(.DEPTH(DEPTH)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dmem_en    (dmem_en),
        .re         (re),
        .we         (we),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .fault      (fault),
        .fault_code (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0]  mm [4*DEPTH];
    logic [31:0] exp_rdata  = 32'h0;
    logic        exp_rvalid = 1'b0;
    logic        exp_fault  = 1'b0;
    logic [1:0]  exp_code   = 2'b00;
    logic        prev_rst   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input int a);
        logic [7:0]  b;
        logic [15:0] h;
        b = mm[a];
        h = (f3[1:0] == 2'b01) ? {mm[a+1], mm[a]} : 16'h0;
        case (f3)
            3'b000:  return 32'($signed(b));
            3'b100:  return {24'h0, b};
            3'b001:  return 32'($signed(h));
            3'b101:  return {16'h0, h};
            default: return {mm[a+3], mm[a+2], mm[a+1], mm[a]};
        endcase
    endfunction

    // One clock cycle: drive inputs just after a rising edge, check at the
    // falling edge the outputs produced by the previous cycle's access, then
    // advance the model with this cycle's inputs.
    task automatic do_cycle(input logic rs, input logic en, input logic r, input logic w,
                            input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic [1:0] code;
        int         ai;
        rst_n = rs; dmem_en = en; re = r; we = w; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        check("rvalid", {31'h0, rvalid}, {31'h0, exp_rvalid & rs});
        if (rs || prev_rst) begin
            check("rdata", rdata, exp_rdata);
            check("fault", {31'h0, fault}, {31'h0, exp_fault});
            check("fault_code", {30'h0, fault_code}, {30'h0, exp_code});
        end
        // Advance the model
        prev_rst   = !rs;
        exp_rvalid = 1'b0;
        exp_fault  = 1'b0;
        if (!rs) begin
            exp_rdata = 32'h0;
            exp_code  = 2'b00;
        end else if (en && (r || w)) begin
            if ((r && w) || (w && f3[2]) || f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)
                code = 2'b11;
            else if ((f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00))
                code = 2'b01;
            else if (a >= 32'(4 * DEPTH))
                code = 2'b10;
            else
                code = 2'b00;
            if (code != 2'b00) begin
                exp_fault = 1'b1;
                exp_code  = code;
            end else begin
                ai = int'(a);
                if (w) begin
                    mm[ai] = wd[7:0];
                    if (f3[1:0] != 2'b00) mm[ai+1] = wd[15:8];
                    if (f3[1:0] == 2'b10) begin
                        mm[ai+2] = wd[23:16];
                        mm[ai+3] = wd[31:24];
                    end
                end else begin
                    exp_rdata  = model_load(f3, ai);
                    exp_rvalid = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [2:0]  rf;
        logic        rr;
        logic        rw;
        logic        ren;
        logic        rrs;

        rst_n = 1'b0; dmem_en = 1'b0; re = 1'b0; we = 1'b0;
        funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        @(posedge clk);
        #1;
        // Reset state, including a strobe while in reset
        do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0);

        // Fill memory with known contents
        for (int i = 0; i < DEPTH; i++)
            do_cycle(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'(i * 4), $urandom);

        // Store word then LB / LBU
        do_cycle(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h10, 32'h8000_00FF);
        do_cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 32'h10, 32'h0);
        do_cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'b100, 32'h13, 32'h0);
        idle();
        check("lbu_0x13_held", rdata, 32'h0000_0080);

        // Half store over a word, then LW / LHU
        do_cycle(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h20, 32'hAABB_CCDD);
        do_cycle(1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 32'h22, 32'h0000_1234);
        do_cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        do_cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'b101, 32'h22, 32'h0);
        idle();
        check("lhu_0x22_held", rdata, 32'h0000_1234);

        // Misaligned word load and store, then confirm word 0x04 untouched
        do_cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h06, 32'h0);
        do_cycle(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h06, 32'hDEAD_BEEF);
        do_cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h04, 32'h0);

        // Out of range, then illegal beats misaligned
        do_cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h1000, 32'h0);
        do_cycle(1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 32'h1001, 32'h0);
        idle();
        check("fault_code_held", {30'h0, fault_code}, 32'h3);

        // Load without strobe; store under reset then load
        do_cycle(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
        do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 32'h30, 32'h1111_2222);
        do_cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h30, 32'h0);

        // Load followed by reset: cancelled
        do_cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        idle();
        check("cancel_rdata_zero", rdata, 32'h0);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            ra = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH + 63));
            if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
            rf  = ($urandom_range(0, 7) == 0) ? 3'($urandom) :
                  3'({$urandom_range(0, 1) == 1, 2'($urandom_range(0, 2))});
            rr  = ($urandom_range(0, 1) == 1);
            rw  = ($urandom_range(0, 9) == 0) ? 1'b1 : !rr;
            ren = ($urandom_range(0, 9) != 0);
            rrs = ($urandom_range(0, 29) != 0);
            do_cycle(rrs, ren, rr, rw, rf, ra, $urandom);
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
